// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// (port 0, read-only) and the load/store unit (port 1, read/write).
// One requester is granted at a time. Its request is latched onto the
// registered memory interface. mem_sel drives the address/data muxes in
// front of the memory.
// Data has priority. Fetch is protected from starvation, and a transaction
// that sees no mem_ack for TIMEOUT cycles is aborted.
//
// Ports:
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   req0, addr0                fetch request (held until done0) and address
//   done0, err0, rdata0        fetch completion pulse, timeout flag, read data
//   req1, we1, addr1,          data request (held until done1), write strobe,
//   wdata1, be1                address, write data, byte enables
//   done1, err1, rdata1        data completion pulse, timeout flag, load data
//   mem_sel                    mux select: 0 = port 0, 1 = port 1
//   mem_req, mem_we, mem_addr, registered memory request, held until mem_ack
//   mem_wdata, mem_be
//   mem_ack, mem_rdata         memory completion and read data
module mem_port_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    output logic          done0,
    output logic          err0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic [3:0]    be1,
    output logic          done1,
    output logic          err1,
    output logic [DW-1:0] rdata1,
    output logic          mem_sel,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
    localparam logic [7:0] TmoLast   = 8'(TIMEOUT - 1);
    localparam bit         TmoEn     = (TIMEOUT != 0);

    typedef enum logic [1:0] {StIdle, StBusy0, StBusy1} state_e;

    state_e        state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic [7:0]    tmo_q, tmo_d;

    logic          done0_q, done0_d, err0_q, err0_d;
    logic          done1_q, done1_d, err1_q, err1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          mem_sel_q, mem_sel_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;

    logic          req0_eff, req1_eff, grant0, grant1, tmo_hit, finish;
    logic [DW-1:0] fin_rdata;

    // A requester still holding req in its own done cycle must not be regranted.
    assign req0_eff = req0 & ~done0_q;
    assign req1_eff = req1 & ~done1_q;
    assign grant0   = req0_eff & (~req1_eff | (starve_q == StarveMax));
    assign grant1   = req1_eff & ~grant0;
    assign tmo_hit  = TmoEn && (tmo_q == TmoLast);
    // mem_ack takes precedence over a timeout in the same cycle.
    assign finish   = mem_ack | tmo_hit;
    assign fin_rdata = (mem_ack && !mem_we_q) ? mem_rdata : '0;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            tmo_q       <= '0;
            done0_q     <= 1'b0;
            err0_q      <= 1'b0;
            rdata0_q    <= '0;
            done1_q     <= 1'b0;
            err1_q      <= 1'b0;
            rdata1_q    <= '0;
            mem_sel_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            done0_q     <= done0_d;
            err0_q      <= err0_d;
            rdata0_q    <= rdata0_d;
            done1_q     <= done1_d;
            err1_q      <= err1_d;
            rdata1_q    <= rdata1_d;
            mem_sel_q   <= mem_sel_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (grant0) begin
                    state_d = StBusy0;
                end else if (grant1) begin
                    state_d = StBusy1;
                end
            end
            StBusy0, StBusy1: begin
                if (finish) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and counters.
    always_comb begin
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        done0_d     = 1'b0;
        err0_d      = err0_q;
        rdata0_d    = rdata0_q;
        done1_d     = 1'b0;
        err1_d      = err1_q;
        rdata1_d    = rdata1_q;
        mem_sel_d   = mem_sel_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        case (state_q)
            StIdle: begin
                mem_we_d = 1'b0;
                if (grant0) begin
                    mem_req_d   = 1'b1;
                    mem_sel_d   = 1'b0;
                    mem_addr_d  = addr0;
                    mem_wdata_d = '0;
                    mem_be_d    = 4'hF;
                    starve_d    = '0;
                    tmo_d       = '0;
                end else if (grant1) begin
                    mem_req_d   = 1'b1;
                    mem_sel_d   = 1'b1;
                    mem_we_d    = we1;
                    mem_addr_d  = addr1;
                    mem_wdata_d = wdata1;
                    mem_be_d    = be1;
                    tmo_d       = '0;
                    if (req0_eff && (starve_q != StarveMax)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            StBusy0, StBusy1: begin
                if (finish) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    tmo_d     = '0;
                    if (state_q == StBusy1) begin
                        done1_d  = 1'b1;
                        err1_d   = ~mem_ack;
                        rdata1_d = fin_rdata;
                    end else begin
                        done0_d  = 1'b1;
                        err0_d   = ~mem_ack;
                        rdata0_d = fin_rdata;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign done0     = done0_q;
    assign err0      = err0_q;
    assign rdata0    = rdata0_q;
    assign done1     = done1_q;
    assign err1      = err1_q;
    assign rdata1    = rdata1_q;
    assign mem_sel   = mem_sel_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule
